// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: owner/state values and burst counter sizing.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  // Burst counter must hold 0..max_burst inclusive.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating event counters for core stall cycles and DMA wait cycles.
// Latency: counts appear one cycle after the event; no backpressure.
module dmem_arb_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_stall_evt,
  input  logic        dma_wait_evt,
  output logic [31:0] stat_core_stall,
  output logic [31:0] stat_dma_wait
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_core_stall <= '0;
      stat_dma_wait   <= '0;
    end else begin
      if (core_stall_evt && !(&stat_core_stall)) stat_core_stall <= stat_core_stall + 32'd1;
      if (dma_wait_evt && !(&stat_dma_wait))     stat_dma_wait   <= stat_dma_wait + 32'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter for the single data-memory port; optional counters under DMEM_ARB_STATS_EN.
// Latency: zero-cycle grant, mux and stall from inputs plus registered owner/burst state.
// Backpressure: losing core sees core_stall; DMA sees dma_gnt low and must hold its request.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_core_stall,
  output logic [31:0]       stat_dma_wait
`endif
);

  localparam int BW = burst_cnt_w(MAX_BURST);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  owner_e        last, last_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          core_gnt, dma_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last      <= OWN_IDLE;
      burst_cnt <= '0;
    end else begin
      last      <= last_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    core_gnt = 1'b0;
    dma_sel  = 1'b0;
    if (rst) begin
      if (core_req && dma_req) begin
        unique case (last)
          OWN_CORE: dma_sel = 1'b1;
          OWN_DMA: begin
            if (burst_cnt < BURST_MAX) dma_sel = 1'b1;
            else                       core_gnt = 1'b1;
          end
          default: core_gnt = 1'b1;
        endcase
      end else if (core_req) begin
        core_gnt = 1'b1;
      end else if (dma_req) begin
        dma_sel = 1'b1;
      end
    end
  end

  // Burst length saturates so a DMA-only stream runs uncapped until the core shows up.
  always_comb begin
    last_nxt  = OWN_IDLE;
    burst_nxt = '0;
    if (dma_sel) begin
      last_nxt = OWN_DMA;
      if (last != OWN_DMA)             burst_nxt = BW'(1);
      else if (burst_cnt == BURST_MAX) burst_nxt = burst_cnt;
      else                             burst_nxt = burst_cnt + BW'(1);
    end else if (core_gnt) begin
      last_nxt = OWN_CORE;
    end
  end

  always_comb begin
    mem_addr   = dma_sel ? dma_addr  : core_addr;
    mem_wdata  = dma_sel ? dma_wdata : core_wdata;
    mem_we     = dma_sel ? dma_we    : (core_gnt & core_we);
    core_rdata = mem_rdata;
    dma_rdata  = mem_rdata;
    core_stall = rst & core_req & ~core_gnt;
    dma_gnt    = dma_sel;
  end

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clk             (clk),
    .rst             (rst),
    .core_stall_evt  (core_stall),
    .dma_wait_evt    (dma_req & ~dma_gnt),
    .stat_core_stall (stat_core_stall),
    .stat_dma_wait   (stat_dma_wait)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model behind the port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, dma_req, dma_we;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        core_stall, dma_gnt, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_core_stall, stat_dma_wait;
`endif

  logic [31:0] mem [0:255];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_rdata  (dma_rdata),
    .dma_gnt    (dma_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_core_stall (stat_core_stall),
    .stat_dma_wait   (stat_dma_wait)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with both sides requesting writes.
    rst = 1'b0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'h0;
    dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 32'h44; dma_wdata  = 32'h0;
    @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_core_stall", core_stall, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    next_cycle();
    @(negedge clk);
    chk("rst2_dma_gnt", dma_gnt, 0);
    chk("rst2_mem_we", mem_we, 0);
    next_cycle();

    // Release with both requesting: C D D D D C D D D D.
    rst = 1'b1; core_we = 1'b0; dma_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("alt_dma_gnt[%0d]", i), dma_gnt, ((i % 5) != 0) ? 1 : 0);
      chk($sformatf("alt_stall[%0d]", i), core_stall, ((i % 5) != 0) ? 1 : 0);
      chk($sformatf("alt_addr[%0d]", i), mem_addr, ((i % 5) != 0) ? 32'h44 : 32'h40);
      next_cycle();
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stat_core_stall", stat_core_stall, 8);
    chk("stat_dma_wait", stat_dma_wait, 2);
`endif

    core_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    chk("idle_stall", core_stall, 0);
    chk("idle_dma_gnt", dma_gnt, 0);
    chk("idle_mem_we", mem_we, 0);
    next_cycle();

    // Core store then load.
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_addr", mem_addr, 32'h10);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_stall", core_stall, 0);
    next_cycle();
    core_we = 1'b0;
    @(negedge clk);
    chk("ld_rdata", core_rdata, 32'hDEADBEEF);
    chk("ld_mem_we", mem_we, 0);
    chk("ld_stall", core_stall, 0);
    next_cycle();

    core_we = 1'b1; core_addr = 32'h208; core_wdata = 32'h55AA55AA;
    next_cycle();

    // Uncapped DMA-only stream.
    core_req = 1'b0; core_we = 1'b0; dma_req = 1'b1; dma_we = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dma_addr = 32'h100 + 32'(4 * i); dma_wdata = 32'hA5000000 + 32'(i);
      @(negedge clk);
      chk($sformatf("stream_gnt[%0d]", i), dma_gnt, 1);
      next_cycle();
    end

    // Saturated burst: core joining wins immediately.
    core_req = 1'b1; core_addr = 32'h100; dma_we = 1'b0;
    @(negedge clk);
    chk("cap_stall", core_stall, 0);
    chk("cap_dma_gnt", dma_gnt, 0);
    chk("cap_rdata", core_rdata, 32'hA5000000);
    next_cycle();
    dma_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      core_addr = 32'h100 + 32'(4 * i);
      @(negedge clk);
      chk($sformatf("rb[%0d]", i), core_rdata, 32'hA5000000 + 32'(i));
      next_cycle();
    end

    // Reset pulse during the third DMA beat.
    core_req = 1'b0; dma_req = 1'b1; dma_we = 1'b1;
    dma_addr = 32'h200; dma_wdata = 32'h11111111;
    next_cycle();
    dma_addr = 32'h204; dma_wdata = 32'h22222222;
    next_cycle();
    dma_addr = 32'h208; dma_wdata = 32'h33333333;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rp_mem_we", mem_we, 0);
    chk("rp_dma_gnt", dma_gnt, 0);
    next_cycle();
    rst = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 32'h208; dma_we = 1'b0;
    @(negedge clk);
    chk("rp_core_first_stall", core_stall, 0);
    chk("rp_core_first_dma", dma_gnt, 0);
    chk("rp_beat3_unwritten", core_rdata, 32'h55AA55AA);
    next_cycle();
    dma_req = 1'b0; core_addr = 32'h204;
    @(negedge clk);
    chk("rp_beat2_written", core_rdata, 32'h22222222);
    next_cycle();

    // Requests dropping mid-burst return arbitration to the IDLE rule.
    core_req = 1'b0; dma_req = 1'b1;
    next_cycle();
    next_cycle();
    dma_req = 1'b0;
    next_cycle();
    core_req = 1'b1; dma_req = 1'b1;
    @(negedge clk);
    chk("drop_core_first", dma_gnt, 0);
    chk("drop_core_stall", core_stall, 0);
    next_cycle();
    @(negedge clk);
    chk("drop_then_dma", dma_gnt, 1);
    next_cycle();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
